// File: rtl/visited_pkg.sv
// Shared FSM state type and default bitmap depth for the visited-vertex block.
package visited_pkg;

  localparam int DEPTH_DEFAULT = 1024;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/xilinx_single_port_ram_read_first.sv
// Single-port read-first block RAM; 2-cycle read with HIGH_PERFORMANCE output register, 1 with LOW_LATENCY.
// Accepts an access every cycle, no backpressure.
module xilinx_single_port_ram_read_first #(
  parameter int    RAM_WIDTH       = 1,
  parameter int    RAM_DEPTH       = 1024,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic                         clka,
  input  logic                         wea,
  input  logic                         ena,
  input  logic                         rsta,
  input  logic                         regcea,
  output logic [RAM_WIDTH-1:0]         douta
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data;

  // Read-first: the read returns the contents from before this cycle's write.
  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) mem[addra] <= dina;
      ram_data <= mem[addra];
    end
  end

  generate
    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_out_reg
      assign douta = ram_data;
    end else begin : g_out_reg
      logic [RAM_WIDTH-1:0] douta_reg;
      always_ff @(posedge clka) begin
        if (rsta) douta_reg <= '0;
        else if (regcea) douta_reg <= ram_data;
      end
      assign douta = douta_reg;
    end
  endgenerate

endmodule

// File: rtl/visited_tas.sv
// Visited-vertex bitmap with atomic test-and-set; result 2 cycles after accept, in order.
// v_ready_out low during the DEPTH-cycle clear sweep; results cannot be stalled.
module visited_tas
  import visited_pkg::*;
#(
  parameter int PROC_BITS = 0,
  parameter int DEPTH     = DEPTH_DEFAULT
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [32+PROC_BITS-1:0]   v_addr_in,
  input  logic                      v_addr_valid_in,
  input  logic                      v_mark_in,
  output logic                      v_ready_out,
  input  logic                      clear_in,
  output logic                      visited_out,
  output logic                      valid_v_out,
  output logic                      range_err_out,
  output logic                      clear_busy_out,
  output logic [$clog2(DEPTH):0]    count_out
);

  localparam int                ADDR_W     = $clog2(DEPTH);
  localparam int                VA_W       = 32 + PROC_BITS;
  localparam logic [ADDR_W-1:0] SWEEP_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_MAX    = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic              accept;
  logic              in_range;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              ram_din;
  logic              ram_dout;
  logic              s1_vld, s1_mark, s1_err;
  logic              s2_vld, s2_mark, s2_err;
  logic [ADDR_W:0]   count_q;

  // Any bit at or above ADDR_W (including processor tag bits) is out of range.
  assign in_range = (v_addr_in[VA_W-1:ADDR_W] == '0);
  assign accept   = v_addr_valid_in && v_ready_out;

  always_comb begin
    state_d        = state_q;
    sweep_d        = sweep_q;
    v_ready_out    = 1'b0;
    clear_busy_out = 1'b0;
    ram_addr       = v_addr_in[ADDR_W-1:0];
    ram_we         = 1'b0;
    ram_din        = 1'b1;
    case (state_q)
      IDLE: begin
        v_ready_out = 1'b1;
        ram_we      = v_addr_valid_in && v_mark_in && in_range;
        if (clear_in) begin
          state_d = CLEAR;
          sweep_d = '0;
        end
      end
      CLEAR: begin
        clear_busy_out = 1'b1;
        ram_addr       = sweep_q;
        ram_we         = 1'b1;
        ram_din        = 1'b0;
        sweep_d        = sweep_q + 1'b1;
        if (sweep_q == SWEEP_LAST) state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= CLEAR;
      sweep_q <= '0;
      s1_vld  <= 1'b0;
      s1_mark <= 1'b0;
      s1_err  <= 1'b0;
      s2_vld  <= 1'b0;
      s2_mark <= 1'b0;
      s2_err  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      s1_vld  <= accept;
      s1_mark <= v_mark_in;
      s1_err  <= !in_range;
      s2_vld  <= s1_vld;
      s2_mark <= s1_mark;
      s2_err  <= s1_err;
      // Results landing during a sweep are not counted; the sweep ends with zero.
      if (state_q == CLEAR)
        count_q <= '0;
      else if (s2_vld && s2_mark && !s2_err && !ram_dout && (count_q != CNT_MAX))
        count_q <= count_q + 1'b1;
    end
  end

  xilinx_single_port_ram_read_first #(
    .RAM_WIDTH       (1),
    .RAM_DEPTH       (DEPTH),
    .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
  ) u_bitmap (
    .addra  (ram_addr),
    .dina   (ram_din),
    .clka   (clk_in),
    .wea    (ram_we),
    .ena    (1'b1),
    .rsta   (rst_in),
    .regcea (1'b1),
    .douta  (ram_dout)
  );

  assign valid_v_out   = s2_vld;
  assign visited_out   = s2_vld && (s2_err || ram_dout);
  assign range_err_out = s2_vld && s2_err;
  assign count_out     = count_q;

endmodule

// File: tb/tb_visited_tas.sv
// Bench for visited_tas: directed scenarios plus randomized traffic against a bitmap model.
module tb_visited_tas;

  logic        clk_in;
  logic        rst_in;
  logic [31:0] v_addr_in;
  logic        v_addr_valid_in;
  logic        v_mark_in;
  logic        v_ready_out;
  logic        clear_in;
  logic        visited_out;
  logic        valid_v_out;
  logic        range_err_out;
  logic        clear_busy_out;
  logic [10:0] count_out;

  int checks = 0;
  int errors = 0;

  bit model_bits [1024];
  int model_count;

  typedef struct {
    logic vld;
    logic vis;
    logic err;
  } exp_t;

  exp_t pipe[$];

  visited_tas dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .v_addr_in       (v_addr_in),
    .v_addr_valid_in (v_addr_valid_in),
    .v_mark_in       (v_mark_in),
    .v_ready_out     (v_ready_out),
    .clear_in        (clear_in),
    .visited_out     (visited_out),
    .valid_v_out     (valid_v_out),
    .range_err_out   (range_err_out),
    .clear_busy_out  (clear_busy_out),
    .count_out       (count_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    v_addr_valid_in = 1'b0;
    v_mark_in       = 1'b0;
    v_addr_in       = '0;
    clear_in        = 1'b0;
  endtask

  task automatic model_clear();
    foreach (model_bits[i]) model_bits[i] = 1'b0;
    model_count = 0;
  endtask

  // Bitmap semantics: out-of-range reports visited with error; TAS sets the bit.
  task automatic model_access(input logic [31:0] a, input logic m,
                              output logic vis, output logic err);
    if (a >= 32'd1024) begin
      vis = 1'b1;
      err = 1'b1;
    end else begin
      err = 1'b0;
      vis = model_bits[a];
      if (m && !model_bits[a]) begin
        model_bits[a] = 1'b1;
        model_count++;
      end
    end
  endtask

  // Issues one request and samples the result cycle two cycles later.
  task automatic single_req(input logic [31:0] a, input logic m,
                            output logic seen, output logic vis, output logic err);
    v_addr_in       = a;
    v_mark_in       = m;
    v_addr_valid_in = 1'b1;
    step();
    idle_inputs();
    step();
    seen = valid_v_out;
    vis  = visited_out;
    err  = range_err_out;
  endtask

  task automatic test_reset();
    int bad;
    rst_in = 1'b1;
    idle_inputs();
    step();
    step();
    rst_in = 1'b0;
    model_clear();
    checks++; if (valid_v_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d exp 0", valid_v_out); end
    checks++; if (visited_out !== 1'b0) begin errors++; $display("FAIL reset_visited got %0d exp 0", visited_out); end
    checks++; if (range_err_out !== 1'b0) begin errors++; $display("FAIL reset_range_err got %0d exp 0", range_err_out); end
    checks++; if (count_out !== 11'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_out); end
    checks++; if (v_ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready got %0d exp 0", v_ready_out); end
    checks++; if (clear_busy_out !== 1'b1) begin errors++; $display("FAIL reset_busy got %0d exp 1", clear_busy_out); end
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (v_ready_out !== 1'b0 || clear_busy_out !== 1'b1) bad++;
      step();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL reset_sweep_cycles got %0d bad cycles exp 0", bad); end
    checks++; if (v_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %0d exp 1", v_ready_out); end
    checks++; if (clear_busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy_after got %0d exp 0", clear_busy_out); end
    checks++; if (count_out !== 11'd0) begin errors++; $display("FAIL reset_count_after got %0d exp 0", count_out); end
  endtask

  task automatic test_tas_back_to_back();
    logic v1, e1, v2, e2;
    model_access(32'd5, 1'b1, v1, e1);
    model_access(32'd5, 1'b1, v2, e2);
    v_addr_in       = 32'd5;
    v_mark_in       = 1'b1;
    v_addr_valid_in = 1'b1;
    step();
    checks++; if (valid_v_out !== 1'b0) begin errors++; $display("FAIL tas_early_valid got %0d exp 0", valid_v_out); end
    step();
    idle_inputs();
    checks++; if (valid_v_out !== 1'b1) begin errors++; $display("FAIL tas_first_valid got %0d exp 1", valid_v_out); end
    checks++; if (visited_out !== v1) begin errors++; $display("FAIL tas_first_visited got %0d exp %0d", visited_out, v1); end
    step();
    checks++; if (valid_v_out !== 1'b1) begin errors++; $display("FAIL tas_second_valid got %0d exp 1", valid_v_out); end
    checks++; if (visited_out !== v2) begin errors++; $display("FAIL tas_second_visited got %0d exp %0d", visited_out, v2); end
    checks++; if (range_err_out !== e2) begin errors++; $display("FAIL tas_second_err got %0d exp %0d", range_err_out, e2); end
    step();
    checks++; if (valid_v_out !== 1'b0) begin errors++; $display("FAIL tas_trailing_valid got %0d exp 0", valid_v_out); end
    checks++; if (count_out !== 11'(model_count)) begin errors++; $display("FAIL tas_count got %0d exp %0d", count_out, model_count); end
  endtask

  task automatic test_query();
    logic seen, vis, err, ev, ee;
    for (int k = 0; k < 2; k++) begin
      model_access(32'd7, 1'b0, ev, ee);
      single_req(32'd7, 1'b0, seen, vis, err);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL query_valid got %0d exp 1", seen); end
      checks++; if (vis !== ev) begin errors++; $display("FAIL query_visited got %0d exp %0d", vis, ev); end
      checks++; if (err !== ee) begin errors++; $display("FAIL query_err got %0d exp %0d", err, ee); end
    end
    step();
    checks++; if (count_out !== 11'(model_count)) begin errors++; $display("FAIL query_count got %0d exp %0d", count_out, model_count); end
  endtask

  task automatic test_range();
    logic seen, vis, err, ev, ee;
    model_access(32'd1024, 1'b1, ev, ee);
    single_req(32'd1024, 1'b1, seen, vis, err);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL range_valid got %0d exp 1", seen); end
    checks++; if (vis !== ev) begin errors++; $display("FAIL range_visited got %0d exp %0d", vis, ev); end
    checks++; if (err !== ee) begin errors++; $display("FAIL range_err got %0d exp %0d", err, ee); end
    step();
    checks++; if (count_out !== 11'(model_count)) begin errors++; $display("FAIL range_count got %0d exp %0d", count_out, model_count); end
    model_access(32'd0, 1'b0, ev, ee);
    single_req(32'd0, 1'b0, seen, vis, err);
    checks++; if (vis !== ev) begin errors++; $display("FAIL range_addr0_visited got %0d exp %0d", vis, ev); end
    checks++; if (err !== ee) begin errors++; $display("FAIL range_addr0_err got %0d exp %0d", err, ee); end
  endtask

  task automatic test_clear();
    logic seen, vis, err, ev, ee;
    int busy_cycles, cyc;
    model_access(32'd3, 1'b1, ev, ee);
    single_req(32'd3, 1'b1, seen, vis, err);
    model_access(32'd4, 1'b1, ev, ee);
    single_req(32'd4, 1'b1, seen, vis, err);
    step();
    checks++; if (count_out !== 11'(model_count)) begin errors++; $display("FAIL clear_pre_count got %0d exp %0d", count_out, model_count); end
    model_access(32'd9, 1'b1, ev, ee);
    v_addr_in       = 32'd9;
    v_mark_in       = 1'b1;
    v_addr_valid_in = 1'b1;
    clear_in        = 1'b1;
    step();
    idle_inputs();
    checks++; if (clear_busy_out !== 1'b1) begin errors++; $display("FAIL clear_enter_busy got %0d exp 1", clear_busy_out); end
    busy_cycles = 0;
    cyc = 0;
    while (v_ready_out !== 1'b1 && cyc < 3000) begin
      if (cyc == 1) begin
        checks++; if (valid_v_out !== 1'b1) begin errors++; $display("FAIL clear_inflight_valid got %0d exp 1", valid_v_out); end
        checks++; if (visited_out !== ev) begin errors++; $display("FAIL clear_inflight_visited got %0d exp %0d", visited_out, ev); end
      end
      clear_in = (cyc == 300);
      if (clear_busy_out === 1'b1) busy_cycles++;
      step();
      cyc++;
    end
    clear_in = 1'b0;
    model_clear();
    checks++; if (busy_cycles != 1024) begin errors++; $display("FAIL clear_busy_cycles got %0d exp 1024", busy_cycles); end
    checks++; if (count_out !== 11'(model_count)) begin errors++; $display("FAIL clear_count got %0d exp %0d", count_out, model_count); end
    for (int k = 0; k < 3; k++) begin
      logic [31:0] a;
      a = (k == 0) ? 32'd3 : (k == 1) ? 32'd4 : 32'd9;
      model_access(a, 1'b0, ev, ee);
      single_req(a, 1'b0, seen, vis, err);
      checks++; if (vis !== ev) begin errors++; $display("FAIL clear_query_%0d got %0d exp %0d", a, vis, ev); end
    end
  endtask

  task automatic test_random();
    exp_t e;
    pipe.delete();
    for (int i = 0; i < 402; i++) begin
      logic go, mk, ev, ee;
      logic [31:0] a;
      int r;
      checks++; if (v_ready_out !== 1'b1) begin errors++; $display("FAIL rand_ready cycle %0d got %0d exp 1", i, v_ready_out); end
      go = (i < 400) && ($urandom_range(0, 9) < 7);
      mk = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'(1024 + $urandom_range(0, 40));
      else if (r == 2) a = 32'($urandom_range(0, 1023));
      else             a = 32'($urandom_range(0, 31));
      ev = 1'b0;
      ee = 1'b0;
      if (go) model_access(a, mk, ev, ee);
      e.vld = go;
      e.vis = ev;
      e.err = ee;
      pipe.push_back(e);
      v_addr_in       = a;
      v_mark_in       = mk;
      v_addr_valid_in = go;
      step();
      if (pipe.size() == 2) begin
        e = pipe.pop_front();
        checks++; if (valid_v_out !== e.vld) begin errors++; $display("FAIL rand_valid cycle %0d got %0d exp %0d", i, valid_v_out, e.vld); end
        if (e.vld) begin
          checks++; if (visited_out !== e.vis) begin errors++; $display("FAIL rand_visited cycle %0d got %0d exp %0d", i, visited_out, e.vis); end
          checks++; if (range_err_out !== e.err) begin errors++; $display("FAIL rand_err cycle %0d got %0d exp %0d", i, range_err_out, e.err); end
        end
      end
    end
    idle_inputs();
    step();
    checks++; if (count_out !== 11'(model_count)) begin errors++; $display("FAIL rand_count got %0d exp %0d", count_out, model_count); end
  endtask

  task automatic test_reset_mid_sweep();
    logic seen, vis, err, ev, ee;
    int n;
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    model_clear();
    for (int i = 0; i < 500; i++) step();
    checks++; if (clear_busy_out !== 1'b1) begin errors++; $display("FAIL midrst_busy got %0d exp 1", clear_busy_out); end
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    checks++; if (v_ready_out !== 1'b0) begin errors++; $display("FAIL midrst_ready got %0d exp 0", v_ready_out); end
    n = 0;
    while (v_ready_out !== 1'b1 && n < 3000) begin
      step();
      n++;
    end
    checks++; if (n != 1024) begin errors++; $display("FAIL midrst_sweep_len got %0d exp 1024", n); end
    checks++; if (count_out !== 11'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", count_out); end
    model_access(32'd5, 1'b0, ev, ee);
    single_req(32'd5, 1'b0, seen, vis, err);
    checks++; if (vis !== ev) begin errors++; $display("FAIL midrst_query got %0d exp %0d", vis, ev); end
  endtask

  initial begin
    rst_in = 1'b1;
    idle_inputs();
    test_reset();
    test_tas_back_to_back();
    test_query();
    test_range();
    test_clear();
    test_random();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/visited_tas.md
VISITED_TAS -- requirements
Module: visited_tas

Interface
REQ-001 Parameter PROC_BITS, default 0: extra vertex-address bits for multi-processor tagging; address width is 32+PROC_BITS.
REQ-002 Parameter DEPTH, default 1024: bitmap entries (power of two); ADDR_W = $clog2(DEPTH) is derived, not overridable.
REQ-003 clk_in  input  1: single clock; all logic SHALL be rising-edge.
REQ-004 rst_in  input  1: synchronous, active-high reset.
REQ-005 v_addr_in  input  32+PROC_BITS: vertex address.
REQ-006 v_addr_valid_in  input  1: request strobe.
REQ-007 v_mark_in  input  1: 1 = test-and-set, 0 = query only.
REQ-008 v_ready_out  output  1: request accepted when v_addr_valid_in && v_ready_out.
REQ-009 clear_in  input  1: single-cycle pulse; starts a full bitmap clear.
REQ-010 visited_out  output  1: bit value before this request.
REQ-011 valid_v_out  output  1: one-cycle pulse qualifying visited_out and range_err_out.
REQ-012 range_err_out  output  1: request address was >= DEPTH.
REQ-013 clear_busy_out  output  1: clear sweep in progress.
REQ-014 count_out  output  ADDR_W+1: number of bits set since the last clear.

Function
REQ-015 FSM states: CLEAR (sweep addresses 0..DEPTH-1 writing 0, one per cycle), IDLE (serve requests).
REQ-016 v_ready_out SHALL be 1 exactly when state is IDLE.
REQ-017 IDLE accepts at most one request per cycle; back-to-back accepts SHALL be supported with no bubbles.
REQ-018 Accept in cycle N -> valid_v_out high in cycle N+2, fixed; results in acceptance order.
REQ-019 Test-and-set SHALL be atomic: a read-first access at acceptance returns the old bit and writes 1 in the same cycle.
REQ-020 Query-only: no write; returns the current bit.
REQ-021 Same address accepted in consecutive cycles with mark=1: first returns the old value, second returns 1.
REQ-022 Address >= DEPTH (any upper bits set): no RAM write; visited_out=1 and range_err_out=1 at N+2.
REQ-023 count_out increments by 1 in cycle N+2 only when mark=1, in range, and old bit=0; it never wraps (max DEPTH).
REQ-024 clear_in in IDLE: enter CLEAR next cycle; a request accepted in the same cycle is still served; in-flight results SHALL still emerge at N+2.
REQ-025 clear_in during CLEAR: ignored; the sweep is not restarted.
REQ-026 CLEAR lasts exactly DEPTH cycles; count_out=0 when the sweep completes; return to IDLE the following cycle.
REQ-027 clear_busy_out = (state == CLEAR).

Reset
REQ-028 rst_in SHALL force state CLEAR with sweep address 0, so the bitmap is zero after reset without an init file.
REQ-029 Reset values: v_ready_out=0, clear_busy_out=1, valid_v_out=0, visited_out=0, range_err_out=0, count_out=0; in-flight requests are discarded.
REQ-030 rst_in asserted mid-sweep SHALL restart the sweep from address 0.

Structure
REQ-031 Package visited_pkg SHALL hold the FSM state typedef (IDLE, CLEAR) and the default DEPTH constant.
REQ-032 Storage SHALL be one xilinx_single_port_ram_read_first instance: RAM_WIDTH=1, RAM_DEPTH=DEPTH, HIGH_PERFORMANCE, rsta tied to rst_in.
REQ-033 The port mux (sweep address/wea=1/dina=0 versus request address/wea=mark&&in_range/dina=1) and a 2-stage side pipeline (valid, mark, range_err) SHALL sit in visited_tas.

Verification
REQ-034 Reset, then wait: ready=0 for 1024 cycles; clear_busy=1 throughout; then ready=1, count_out=0.
REQ-035 TAS addr 5 in cycle N, repeated in N+1: valid at N+2 with visited=0, at N+3 with visited=1; count_out=1.
REQ-036 Query addr 7 (unmarked) twice: both visited=0; count_out unchanged.
REQ-037 TAS addr 1024 with PROC_BITS=0: visited=1, range_err=1 at N+2; count_out unchanged; a later query of addr 0 returns 0.
REQ-038 Mark addrs 3,4; pulse clear_in in the same cycle as a TAS of addr 9: addr 9 result emerges at N+2 (visited=0); after 1024 busy cycles count_out=0 and queries of 3, 4, 9 return 0.
REQ-039 Assert rst_in at sweep cycle 500: the sweep restarts, taking 1024 more cycles before ready=1.
